pad_mux_ctrl: RTL and testbench

Parametrised pad-function controller between the SoC core and the pad-ring cells. For every bidirectional pad it selects one of NumAlt alternate on-chip functions to drive the pad, and routes the pad input back to the selected function only. Each input path has a synchroniser and an optional glitch filter. Per-pad configuration is software-visible through a simple req/gnt register port.

---
 rtl/pad_mux_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pad_mux_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_mux_ctrl.sv
// Pad-function controller: per-pad alternate-function select on the output
// side, synchronised and optionally glitch-filtered input routed back to the
// selected function only, and a req/gnt register port for per-pad config.
module pad_mux_ctrl #(
   parameter int PadCount    = 32,
   parameter int NumAlt      = 4,
   parameter int FilterDepth = 4,
   parameter int AddrWidth   = 6
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cfg_req_i,
   input  logic                       cfg_we_i,
   input  logic [AddrWidth-1:0]       cfg_addr_i,
   input  logic [31:0]                cfg_wdata_i,
   output logic                       cfg_gnt_o,
   output logic                       cfg_rvalid_o,
   output logic [31:0]                cfg_rdata_o,
   input  logic [NumAlt*PadCount-1:0] alt_o_i,
   input  logic [NumAlt*PadCount-1:0] alt_oe_i,
   output logic [NumAlt*PadCount-1:0] alt_i_o,
   output logic [PadCount-1:0]        pad_c2p_o,
   output logic [PadCount-1:0]        pad_c2p_en_o,
   input  logic [PadCount-1:0]        pad_p2c_i
);

   localparam int SelW = $clog2(NumAlt);
   // FilterDepth is at most 15, so the counter never exceeds 14.
   localparam int CntW = 4;
   localparam logic [AddrWidth-1:0] StatAddr = AddrWidth'(PadCount);
   localparam logic [CntW-1:0]      CntMax   = CntW'(FilterDepth - 1);

   // Per-pad configuration
   logic [PadCount-1:0][SelW-1:0] sel_q;
   logic [PadCount-1:0]           filt_en_q;
   logic [PadCount-1:0]           inv_q;

   // Register-port response
   logic                          vld_p0;
   logic [31:0]                   rdata_p0;

   // Input path: two sync flops, filtered value, stability counter
   logic [PadCount-1:0]           sync_p0;
   logic [PadCount-1:0]           sync_p1;
   logic [PadCount-1:0]           filt_p2;
   logic [PadCount-1:0][CntW-1:0] cnt_q;
   logic [NumAlt*PadCount-1:0]    alt_i_p3;

   // Output path registers
   logic [PadCount-1:0]           c2p_p0;
   logic [PadCount-1:0]           c2p_en_p0;

   logic                          wr_en;
   logic                          rd_en;
   logic [PadCount-1:0]           wr_hit;
   logic [31:0]                   rdata_d;
   logic [PadCount-1:0]           c2p_d;
   logic [PadCount-1:0]           c2p_en_d;
   logic [NumAlt*PadCount-1:0]    alt_i_d;
   logic                          unused_wdata;

   assign cfg_gnt_o    = cfg_req_i;
   assign wr_en        = cfg_req_i & cfg_we_i;
   assign rd_en        = cfg_req_i & ~cfg_we_i;
   assign unused_wdata = ^{cfg_wdata_i[31:10], cfg_wdata_i[7:SelW]};

   assign cfg_rvalid_o = vld_p0;
   assign cfg_rdata_o  = rdata_p0;
   assign pad_c2p_o    = c2p_p0;
   assign pad_c2p_en_o = c2p_en_p0;
   assign alt_i_o      = alt_i_p3;

   // Address decode: per-pad write strobes and the read mux (old values)
   always_comb begin
      wr_hit  = '0;
      rdata_d = '0;
      for (int p = 0; p < PadCount; p++) begin
         if (cfg_addr_i == AddrWidth'(p)) begin
            wr_hit[p]         = wr_en;
            rdata_d[SelW-1:0] = sel_q[p];
            rdata_d[8]        = filt_en_q[p];
            rdata_d[9]        = inv_q[p];
         end
      end
      if (cfg_addr_i == StatAddr) begin
         rdata_d[PadCount-1:0] = filt_p2;
      end
   end

   // Function select: pick the driver per pad, route the input to one function
   always_comb begin
      c2p_d    = '0;
      c2p_en_d = '0;
      alt_i_d  = '0;
      for (int p = 0; p < PadCount; p++) begin
         for (int a = 0; a < NumAlt; a++) begin
            if (sel_q[p] == SelW'(a)) begin
               c2p_d[p]                = alt_o_i[a*PadCount+p];
               c2p_en_d[p]             = alt_oe_i[a*PadCount+p];
               alt_i_d[a*PadCount+p]   = filt_p2[p] ^ inv_q[p];
            end
         end
      end
   end

   // Config registers and the one-cycle-later response
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sel_q     <= '0;
         filt_en_q <= '0;
         inv_q     <= '0;
         vld_p0    <= 1'b0;
         rdata_p0  <= '0;
      end else begin
         vld_p0   <= cfg_req_i;
         rdata_p0 <= rd_en ? rdata_d : '0;
         for (int p = 0; p < PadCount; p++) begin
            if (wr_hit[p]) begin
               sel_q[p]     <= cfg_wdata_i[SelW-1:0];
               filt_en_q[p] <= cfg_wdata_i[8];
               inv_q[p]     <= cfg_wdata_i[9];
            end
         end
      end
   end

   // Input synchroniser and glitch filter; a config write restarts the count
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         filt_p2 <= '0;
         cnt_q   <= '0;
      end else begin
         sync_p0 <= pad_p2c_i;
         sync_p1 <= sync_p0;
         for (int p = 0; p < PadCount; p++) begin
            if (!filt_en_q[p]) begin
               filt_p2[p] <= sync_p1[p];
               cnt_q[p]   <= '0;
            end else if (sync_p1[p] == filt_p2[p]) begin
               cnt_q[p]   <= '0;
            end else if (cnt_q[p] == CntMax) begin
               filt_p2[p] <= ~filt_p2[p];
               cnt_q[p]   <= '0;
            end else begin
               cnt_q[p]   <= cnt_q[p] + CntW'(1);
            end
            if (wr_hit[p]) begin
               cnt_q[p] <= '0;
            end
         end
      end
   end

   // Output registers towards the pad cells and the functions
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         c2p_p0    <= '0;
         c2p_en_p0 <= '0;
         alt_i_p3  <= '0;
      end else begin
         c2p_p0    <= c2p_d;
         c2p_en_p0 <= c2p_en_d;
         alt_i_p3  <= alt_i_d;
      end
   end

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Testbench for pad_mux_ctrl: directed steps followed by a randomized phase
// checked against a history-based reference of the pad controller.
module tb_pad_mux_ctrl;

   localparam int P  = 32;
   localparam int A  = 4;
   localparam int D  = 4;
   localparam int AW = 6;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             cfg_req_i;
   logic             cfg_we_i;
   logic [AW-1:0]    cfg_addr_i;
   logic [31:0]      cfg_wdata_i;
   logic             cfg_gnt_o;
   logic             cfg_rvalid_o;
   logic [31:0]      cfg_rdata_o;
   logic [A*P-1:0]   alt_o_i;
   logic [A*P-1:0]   alt_oe_i;
   logic [A*P-1:0]   alt_i_o;
   logic [P-1:0]     pad_c2p_o;
   logic [P-1:0]     pad_c2p_en_o;
   logic [P-1:0]     pad_p2c_i;

   int checks   = 0;
   int failures = 0;

   pad_mux_ctrl #(
      .PadCount    (P),
      .NumAlt      (A),
      .FilterDepth (D),
      .AddrWidth   (AW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cfg_req_i    (cfg_req_i),
      .cfg_we_i     (cfg_we_i),
      .cfg_addr_i   (cfg_addr_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .cfg_gnt_o    (cfg_gnt_o),
      .cfg_rvalid_o (cfg_rvalid_o),
      .cfg_rdata_o  (cfg_rdata_o),
      .alt_o_i      (alt_o_i),
      .alt_oe_i     (alt_oe_i),
      .alt_i_o      (alt_i_o),
      .pad_c2p_o    (pad_c2p_o),
      .pad_c2p_en_o (pad_c2p_en_o),
      .pad_p2c_i    (pad_p2c_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "simulation time limit reached");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic cfg_write(input logic [AW-1:0] addr, input logic [31:0] data);
      cfg_req_i   = 1'b1;
      cfg_we_i    = 1'b1;
      cfg_addr_i  = addr;
      cfg_wdata_i = data;
      #1;
      chk("gnt_wr", 128'(cfg_gnt_o), 128'(1));
      tick();
      cfg_req_i = 1'b0;
      cfg_we_i  = 1'b0;
      chk("rvalid_wr", 128'(cfg_rvalid_o), 128'(1));
      chk("rdata_wr", 128'(cfg_rdata_o), 128'(0));
   endtask

   task automatic cfg_read(input logic [AW-1:0] addr, input logic [31:0] exp, input string tag);
      cfg_req_i  = 1'b1;
      cfg_we_i   = 1'b0;
      cfg_addr_i = addr;
      #1;
      chk("gnt_rd", 128'(cfg_gnt_o), 128'(1));
      tick();
      cfg_req_i = 1'b0;
      chk("rvalid_rd", 128'(cfg_rvalid_o), 128'(1));
      chk(tag, 128'(cfg_rdata_o), 128'(exp));
   endtask

   // Reference state for the randomized phase
   int           m_sel  [P];
   logic         m_filt [P];
   logic         m_inv  [P];
   logic [31:0]  ph [$];
   logic [31:0]  f_prev;
   logic [31:0]  f_next;
   logic [31:0]  pad;
   logic [127:0] ao;
   logic [127:0] aoe;
   logic [127:0] exp_c2p;
   logic [127:0] exp_en;
   logic [127:0] exp_alt;
   logic         all_diff;
   int           n;

   initial begin
      rst_ni      = 1'b0;
      cfg_req_i   = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_addr_i  = '0;
      cfg_wdata_i = '0;
      alt_o_i     = '1;
      alt_oe_i    = '1;
      pad_p2c_i   = '0;

      // Reset holds drivers off and response idle despite enables at 1
      repeat (3) tick();
      chk("rst_c2p_en", 128'(pad_c2p_en_o), 128'(0));
      chk("rst_c2p", 128'(pad_c2p_o), 128'(0));
      chk("rst_rvalid", 128'(cfg_rvalid_o), 128'(0));
      chk("rst_rdata", 128'(cfg_rdata_o), 128'(0));
      chk("rst_alt_i", alt_i_o, 128'(0));

      // First cycle after release: every pad follows alternate 0
      rst_ni       = 1'b1;
      alt_o_i      = '0;
      alt_o_i[31:0] = 32'hA5A5_0001;
      tick();
      chk("post_rst_pad0", 128'(pad_c2p_o[0]), 128'(1));
      chk("post_rst_c2p", 128'(pad_c2p_o), 128'(32'hA5A5_0001));
      chk("post_rst_en", 128'(pad_c2p_en_o), 128'(32'hFFFF_FFFF));
      chk("idle_gnt", 128'(cfg_gnt_o), 128'(0));

      // Pad 3 switched to alternate 2
      cfg_write(6'd3, 32'h2);
      alt_o_i  = '0;
      alt_oe_i = '0;
      alt_o_i[2*P+3]  = 1'b1;
      alt_oe_i[2*P+3] = 1'b1;
      tick();
      chk("sel2_c2p3", 128'(pad_c2p_o[3]), 128'(1));
      chk("sel2_en3", 128'(pad_c2p_en_o[3]), 128'(1));
      chk("sel2_c2p_all", 128'(pad_c2p_o), 128'(32'h8));
      alt_o_i[0*P+3] = 1'b1;
      alt_o_i[2*P+3] = 1'b0;
      tick();
      chk("sel2_ignore_alt0", 128'(pad_c2p_o[3]), 128'(0));
      chk("sel2_en3_hold", 128'(pad_c2p_en_o[3]), 128'(1));

      // Unfiltered pad 5 on alternate 1: four-cycle latency
      cfg_write(6'd5, 32'h1);
      pad_p2c_i[5] = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("unfilt_lat", 128'(alt_i_o[1*P+5]), 128'(i == 4));
      end
      chk("unfilt_alt0_quiet", 128'(alt_i_o[0*P+5]), 128'(0));

      // Filtered pad 7: short pulse rejected, long level accepted
      cfg_write(6'd7, 32'h100);
      pad_p2c_i[7] = 1'b1;
      repeat (3) tick();
      pad_p2c_i[7] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("filt_reject", 128'(alt_i_o[7]), 128'(0));
      end
      pad_p2c_i[7] = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("filt_lat", 128'(alt_i_o[7]), 128'(i == 7));
      end
      cfg_read(6'd32, 32'h0000_00A0, "status_word");

      // Inverted pad 2, readback and unmapped addresses
      cfg_write(6'd2, 32'h200);
      tick();
      chk("inv_alt_i2", 128'(alt_i_o[2]), 128'(1));
      cfg_read(6'd2, 32'h200, "rd_word2");
      cfg_read(6'd40, 32'h0, "rd_word40");
      cfg_write(6'd40, 32'hFFFF_FFFF);
      cfg_read(6'd40, 32'h0, "rd_word40_after_wr");
      cfg_read(6'd3, 32'h2, "rd_word3");
      cfg_read(6'd7, 32'h100, "rd_word7");
      tick();
      chk("rvalid_idle", 128'(cfg_rvalid_o), 128'(0));

      // Back-to-back write then read of word 1; unused bits read as 0
      cfg_write(6'd1, 32'hFFFF_FFFF);
      cfg_read(6'd1, 32'h303, "b2b_read");

      // Reset together with a pending read drops the response
      cfg_req_i  = 1'b1;
      cfg_we_i   = 1'b0;
      cfg_addr_i = 6'd1;
      rst_ni     = 1'b0;
      tick();
      cfg_req_i = 1'b0;
      chk("rst_drop_rvalid", 128'(cfg_rvalid_o), 128'(0));
      tick();
      rst_ni = 1'b1;
      tick();
      cfg_read(6'd1, 32'h0, "rst_clr_word1");
      cfg_read(6'd3, 32'h0, "rst_clr_word3");

      // Randomized phase: random per-pad config, then random traffic
      pad_p2c_i = '0;
      alt_o_i   = '0;
      alt_oe_i  = '0;
      for (int p = 0; p < P; p++) begin
         m_sel[p]  = int'($urandom_range(0, A - 1));
         m_filt[p] = 1'($urandom_range(0, 1));
         m_inv[p]  = 1'($urandom_range(0, 1));
         cfg_write(AW'(p), {22'h0, m_inv[p], m_filt[p], 6'h0, 2'(m_sel[p])});
      end
      for (int p = 0; p < P; p += 5) begin
         cfg_read(AW'(p), {22'h0, m_inv[p], m_filt[p], 6'h0, 2'(m_sel[p])}, "rnd_readback");
      end
      repeat (20) tick();
      for (int i = 0; i < 8; i++) ph.push_back('0);
      f_prev = '0;
      pad    = '0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         pad = pad ^ ($urandom() & $urandom());
         ao  = {$urandom(), $urandom(), $urandom(), $urandom()};
         aoe = {$urandom(), $urandom(), $urandom(), $urandom()};
         pad_p2c_i = pad;
         alt_o_i   = ao;
         alt_oe_i  = aoe;
         exp_c2p = '0;
         exp_en  = '0;
         exp_alt = '0;
         for (int p = 0; p < P; p++) begin
            exp_c2p[p] = ao[m_sel[p]*P+p];
            exp_en[p]  = aoe[m_sel[p]*P+p];
            exp_alt[m_sel[p]*P+p] = f_prev[p] ^ m_inv[p];
         end
         tick();
         ph.push_back(pad);
         chk("rnd_c2p", 128'(pad_c2p_o), exp_c2p);
         chk("rnd_c2p_en", 128'(pad_c2p_en_o), exp_en);
         chk("rnd_alt_i", alt_i_o, exp_alt);
         // The filter sees the pad value sampled two edges earlier; a filtered
         // value flips once D consecutive samples all disagree with it.
         n = ph.size();
         for (int p = 0; p < P; p++) begin
            if (!m_filt[p]) begin
               f_next[p] = ph[n-3][p];
            end else begin
               all_diff = 1'b1;
               for (int j = 0; j < D; j++) begin
                  if (ph[n-3-j][p] == f_prev[p]) all_diff = 1'b0;
               end
               f_next[p] = all_diff ? ~f_prev[p] : f_prev[p];
            end
         end
         f_prev = f_next;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
